// File: rtl/sys_sequencer.sv
// Sequencer for a 2-column systolic array: configures column count, loads two
// weight rows, swaps the weight bank, then streams skewed input vectors.
module sys_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_col_size,
  input  logic [15:0] cmd_rows,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [31:0] x_data,
  output logic [15:0] col_size_out,
  output logic        col_size_valid_out,
  output logic [31:0] sys_weight_out,
  output logic [1:0]  sys_accept_w,
  output logic        sys_switch_out,
  output logic [31:0] sys_data_out,
  output logic        sys_start_out,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    LOAD_W,
    SWITCH,
    FEED,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] col_size_q;
  logic [15:0] rows_q;
  logic [15:0] x_cnt;
  logic [15:0] drain_cnt;
  logic        w_cnt;
  logic [15:0] lane2_dly;

  logic        cmd_hs;
  logic        cmd_legal;
  logic        w_hs;
  logic        x_hs;
  logic        x_last;
  logic        drain_last;

  // Handshakes decode the state directly so the ready outputs stay loop-free.
  assign cmd_hs     = cmd_valid && (state == IDLE);
  assign cmd_legal  = (cmd_col_size == 16'd1) || (cmd_col_size == 16'd2);
  assign w_hs       = w_valid && (state == LOAD_W);
  assign x_hs       = x_valid && (state == FEED);
  assign x_last     = x_hs && (x_cnt == rows_q - 16'd1);
  assign drain_last = (drain_cnt == DRAIN_LAST);

  assign col_size_out = col_size_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    cmd_ready          = 1'b0;
    w_ready            = 1'b0;
    x_ready            = 1'b0;
    col_size_valid_out = 1'b0;
    sys_switch_out     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_hs && cmd_legal) begin
          state_nxt = CFG;
        end
      end
      CFG: begin
        col_size_valid_out = 1'b1;
        state_nxt          = LOAD_W;
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_hs && w_cnt) begin
          state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        sys_switch_out = 1'b1;
        state_nxt      = (rows_q == 16'd0) ? DRAIN : FEED;
      end
      FEED: begin
        x_ready = 1'b1;
        if (x_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_size_q <= '0;
      rows_q     <= '0;
      w_cnt      <= 1'b0;
      x_cnt      <= '0;
      drain_cnt  <= '0;
    end else begin
      if (cmd_hs && cmd_legal) begin
        col_size_q <= cmd_col_size;
        rows_q     <= cmd_rows;
        w_cnt      <= 1'b0;
        x_cnt      <= '0;
        drain_cnt  <= '0;
      end
      if (w_hs) begin
        w_cnt <= ~w_cnt;
      end
      if (x_hs) begin
        x_cnt <= x_cnt + 16'd1;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 16'd1;
      end
    end
  end

  // Lane 2 trails lane 1 by one cycle through lane2_dly to form the array skew.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err            <= 1'b0;
      done           <= 1'b0;
      sys_accept_w   <= '0;
      sys_weight_out <= '0;
      sys_start_out  <= 1'b0;
      sys_data_out   <= '0;
      lane2_dly      <= '0;
    end else begin
      err           <= cmd_hs && !cmd_legal;
      done          <= (state == DRAIN) && drain_last;
      sys_accept_w  <= w_hs ? {col_size_q == 16'd2, 1'b1} : 2'b00;
      if (w_hs) begin
        sys_weight_out <= w_data;
      end
      sys_start_out        <= x_hs;
      sys_data_out[15:0]   <= x_hs ? x_data[15:0] : '0;
      lane2_dly            <= x_hs ? x_data[31:16] : '0;
      sys_data_out[31:16]  <= lane2_dly;
    end
  end

endmodule

// File: tb/tb_sys_sequencer.sv
// Scoreboard bench for sys_sequencer: expected array outputs are queued with
// their due cycle at each handshake and matched by a negedge monitor.
module tb_sys_sequencer;

  localparam int unsigned DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_col_size;
  logic [15:0] cmd_rows;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x_data;
  logic [15:0] col_size_out;
  logic        col_size_valid_out;
  logic [31:0] sys_weight_out;
  logic [1:0]  sys_accept_w;
  logic        sys_switch_out;
  logic [31:0] sys_data_out;
  logic        sys_start_out;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  sys_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_col_size       (cmd_col_size),
    .cmd_rows           (cmd_rows),
    .w_valid            (w_valid),
    .w_ready            (w_ready),
    .w_data             (w_data),
    .x_valid            (x_valid),
    .x_ready            (x_ready),
    .x_data             (x_data),
    .col_size_out       (col_size_out),
    .col_size_valid_out (col_size_valid_out),
    .sys_weight_out     (sys_weight_out),
    .sys_accept_w       (sys_accept_w),
    .sys_switch_out     (sys_switch_out),
    .sys_data_out       (sys_data_out),
    .sys_start_out      (sys_start_out),
    .done               (done),
    .err                (err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  acc;
  } exp_t;

  exp_t wq[$];
  exp_t l1q[$];
  exp_t l2q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_strobe = 0, n_switch = 0, n_done = 0, n_err = 0;
  int strobe_cyc = -1, switch_cyc = -1, done_cyc = -1, err_cyc = -1;
  logic [15:0] exp_col = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (col_size_valid_out) begin
        n_strobe++;
        strobe_cyc = cyc;
        check("col_size_out", {16'h0, col_size_out}, {16'h0, exp_col});
        check("cmd_ready_cfg", {31'h0, cmd_ready}, 32'h0);
      end
      if (sys_switch_out) begin
        n_switch++;
        switch_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        e = wq.pop_front();
        check("accept_w", {30'h0, sys_accept_w}, {30'h0, e.acc});
        check("weight", sys_weight_out, e.data);
      end else if (sys_accept_w != 2'b00) begin
        check("accept_w_unexp", {30'h0, sys_accept_w}, 32'h0);
      end
      if (l1q.size() > 0 && l1q[0].cyc == cyc) begin
        e = l1q.pop_front();
        check("start", {31'h0, sys_start_out}, 32'h1);
        check("lane1", {16'h0, sys_data_out[15:0]}, e.data);
      end else if (sys_start_out) begin
        check("start_unexp", {31'h0, sys_start_out}, 32'h0);
      end
      if (l2q.size() > 0 && l2q[0].cyc == cyc) begin
        e = l2q.pop_front();
        check("lane2", {16'h0, sys_data_out[31:16]}, e.data);
      end else if (sys_data_out[31:16] != 16'h0) begin
        check("lane2_unexp", {16'h0, sys_data_out[31:16]}, 32'h0);
      end
    end
  end

  task automatic rst_outputs();
    check("rst_ctrl", {24'h0, cmd_ready, w_ready, x_ready, col_size_valid_out,
                       sys_switch_out, sys_start_out, done, err}, 32'h80);
    check("rst_col_size", {16'h0, col_size_out}, 32'h0);
    check("rst_weight", sys_weight_out, 32'h0);
    check("rst_accept_w", {30'h0, sys_accept_w}, 32'h0);
    check("rst_data", sys_data_out, 32'h0);
  endtask

  task automatic send_cmd(input logic [15:0] col, input logic [15:0] rows, output int t);
    cmd_col_size = col;
    cmd_rows     = rows;
    cmd_valid    = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("cmd_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [15:0] col, output int t);
    w_data  = d;
    w_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("w_timeout", 32'h0, 32'h1);
    else wq.push_back('{t + 1, d, (col == 16'd2) ? 2'b11 : 2'b01});
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic send_x(input logic [31:0] d, output int t);
    x_data  = d;
    x_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (x_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("x_timeout", 32'h0, 32'h1);
    else begin
      l1q.push_back('{t + 1, {16'h0, d[15:0]}, 2'b00});
      l2q.push_back('{t + 2, {16'h0, d[31:16]}, 2'b00});
    end
    @(posedge clk);
    #1 x_valid = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] col, input logic [15:0] rows,
                         input int gap_at, input int gap_len, input bit junk);
    int tc, tw, tx, s0, sw0, d0, exp_done;
    logic [31:0] d;
    s0 = n_strobe;
    sw0 = n_switch;
    d0 = n_done;
    tx = 0;
    tw = 0;
    exp_col = col;
    send_cmd(col, rows, tc);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      send_w(d, col, tw);
    end
    check("strobe_cnt", n_strobe, s0 + 1);
    check("strobe_cyc", strobe_cyc, tc + 1);
    // Stray weight beats and commands offered while feeding must be ignored.
    if (junk) begin
      w_valid      = 1'b1;
      w_data       = 32'hDEADBEEF;
      cmd_valid    = 1'b1;
      cmd_col_size = 16'd2;
    end
    for (int i = 0; i < int'(rows); i++) begin
      d = $urandom;
      send_x(d, tx);
      if (i == gap_at) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    w_valid   = 1'b0;
    cmd_valid = 1'b0;
    repeat (DRAIN + 8) @(negedge clk);
    check("switch_cnt", n_switch, sw0 + 1);
    check("switch_cyc", switch_cyc, tw + 1);
    exp_done = (rows == 16'd0) ? tw + int'(DRAIN) + 3 : tx + int'(DRAIN) + 2;
    check("done_cnt", n_done, d0 + 1);
    check("done_cyc", done_cyc, exp_done);
    check("queues_left", wq.size() + l1q.size() + l2q.size(), 32'h0);
    check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic bad_cmd(input logic [15:0] col);
    int t, e0, s0;
    e0 = n_err;
    s0 = n_strobe;
    send_cmd(col, 16'd4, t);
    repeat (3) @(negedge clk);
    check("err_cnt", n_err, e0 + 1);
    check("err_cyc", err_cyc, t + 1);
    check("strobe_none", n_strobe, s0);
    check("cmd_ready_err", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_job();
    int t, d0;
    exp_col = 16'd2;
    send_cmd(16'd2, 16'd6, t);
    for (int i = 0; i < 2; i++) send_w($urandom, 16'd2, t);
    for (int i = 0; i < 2; i++) send_x($urandom, t);
    #3 rst = 1'b0;
    #1;
    rst_outputs();
    wq.delete();
    l1q.delete();
    l2q.delete();
    d0 = n_done;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", n_done, d0);
    check("cmd_ready_after_rst", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmd_valid    = 1'b0;
    cmd_col_size = '0;
    cmd_rows     = '0;
    w_valid      = 1'b0;
    w_data       = '0;
    x_valid      = 1'b0;
    x_data       = '0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    rst_outputs();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    run_job(16'd2, 16'd3, -1, 0, 1'b1);
    run_job(16'd1, 16'd3, -1, 0, 1'b0);
    bad_cmd(16'd0);
    bad_cmd(16'd3);
    bad_cmd(16'hFFFF);
    run_job(16'd2, 16'd4, 1, 2, 1'b0);
    run_job(16'd2, 16'd0, -1, 0, 1'b0);
    run_job(16'd1, 16'd1, -1, 0, 1'b0);
    run_job(16'd2, 16'd300, 150, 3, 1'b0);
    reset_mid_job();
    run_job(16'd2, 16'd3, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
